// File: rtl/dprambe_clr.sv
// Simple dual-port RAM with per-lane byte enables and a self-timed clear sweep
// that initialises every word to CLEAR_VAL after reset or on request.
module dprambe_clr #(
    parameter int                DWIDTH    = 128,
    parameter int                AWIDTH    = 4,
    parameter int                BYTEW     = 8,
    parameter                    REGOUT    = "Y",
    parameter                    RDW_MODE  = "OLD",
    parameter logic [BYTEW-1:0]  CLEAR_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    output logic                      busy,
    input  logic                      wr_en,
    input  logic [AWIDTH-1:0]         wr_addr,
    input  logic [DWIDTH-1:0]         wr_data,
    input  logic [DWIDTH/BYTEW-1:0]   wr_be,
    input  logic                      rd_en,
    input  logic [AWIDTH-1:0]         rd_addr,
    output logic [DWIDTH-1:0]         rd_data,
    output logic                      rd_valid
);

    localparam int                BEWIDTH   = DWIDTH / BYTEW;
    localparam int                DEPTH     = 2 ** AWIDTH;
    localparam logic [AWIDTH:0]   LAST_ADDR = {1'b0, {AWIDTH{1'b1}}};

    if (DWIDTH % BYTEW != 0) begin : g_bad_bytew
        $error("dprambe_clr: DWIDTH must be a multiple of BYTEW");
    end
    if (!(RDW_MODE == "OLD" || RDW_MODE == "NEW")) begin : g_bad_rdw
        $error("dprambe_clr: RDW_MODE must be \"OLD\" or \"NEW\"");
    end
    if (!(REGOUT == "Y" || REGOUT == "N")) begin : g_bad_regout
        $error("dprambe_clr: REGOUT must be \"Y\" or \"N\"");
    end

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_pending;
    logic                w_pending_nxt;
    logic [AWIDTH:0]     r_clr_addr;
    logic [AWIDTH:0]     w_clr_addr_nxt;

    logic [DWIDTH-1:0]   r_mem [DEPTH];
    logic [DWIDTH-1:0]   w_merged;
    logic [DWIDTH-1:0]   w_rd_word;
    logic                w_clr_we;
    logic                w_wr_acc;
    logic                w_rd_acc;

    logic [DWIDTH-1:0]   r_data_p0;
    logic                r_vld_p0;

    assign busy     = r_pending | (r_state == S_CLEAR);
    assign w_clr_we = (r_state == S_CLEAR);
    assign w_wr_acc = wr_en & ~busy;
    assign w_rd_acc = rd_en & ~busy;

    // Sweep control: a pending flag covers the cycle between reset release and sweep start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pending  <= 1'b1;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pending_nxt  = r_pending;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            S_IDLE: begin
                if (r_pending || clear) begin
                    w_state_nxt    = S_CLEAR;
                    w_pending_nxt  = 1'b0;
                    w_clr_addr_nxt = '0;
                end
            end
            S_CLEAR: begin
                w_clr_addr_nxt = r_clr_addr + 1'b1;
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_merged = r_mem[wr_addr];
        for (int i = 0; i < BEWIDTH; i++) begin
            if (wr_be[i]) begin
                w_merged[i*BYTEW +: BYTEW] = wr_data[i*BYTEW +: BYTEW];
            end
        end
    end

    // Array has no reset; its contents are only ever initialised by the sweep.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_addr[AWIDTH-1:0]] <= {BEWIDTH{CLEAR_VAL}};
        end else if (w_wr_acc) begin
            r_mem[wr_addr] <= w_merged;
        end
    end

    if (RDW_MODE == "NEW") begin : g_rdw_new
        assign w_rd_word = (w_wr_acc && (wr_addr == rd_addr)) ? w_merged : r_mem[rd_addr];
    end else begin : g_rdw_old
        assign w_rd_word = r_mem[rd_addr];
    end

    // Read stage p0: array access; data only moves on an accepted read so it holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p0  <= 1'b0;
            r_data_p0 <= '0;
        end else begin
            r_vld_p0 <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_p0 <= w_rd_word;
            end
        end
    end

    if (REGOUT == "Y") begin : g_regout
        logic [DWIDTH-1:0] r_data_p1;
        logic              r_vld_p1;

        // Read stage p1: optional output register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_vld_p1  <= 1'b0;
                r_data_p1 <= '0;
            end else begin
                r_vld_p1 <= r_vld_p0;
                if (r_vld_p0) begin
                    r_data_p1 <= r_data_p0;
                end
            end
        end

        assign rd_data  = r_data_p1;
        assign rd_valid = r_vld_p1;
    end else begin : g_noregout
        assign rd_data  = r_data_p0;
        assign rd_valid = r_vld_p0;
    end

endmodule

// File: tb/tb_dprambe_clr.sv
// Directed bench: instance A (REGOUT "Y", RDW "OLD") and instance B (REGOUT "N",
// RDW "NEW") share all inputs; each is checked against hand-computed values.
module tb_dprambe_clr;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [2:0]  rd_addr;

    logic        busy_a, busy_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dprambe_clr #(.DWIDTH(32), .AWIDTH(3), .BYTEW(8), .REGOUT("Y"), .RDW_MODE("OLD"),
                  .CLEAR_VAL(8'h00)) u_dut_a (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    dprambe_clr #(.DWIDTH(32), .AWIDTH(3), .BYTEW(8), .REGOUT("N"), .RDW_MODE("NEW"),
                  .CLEAR_VAL(8'h00)) u_dut_b (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    // Issues one read (plus whatever write is already driven); B answers after 1 edge, A after 2.
    task automatic do_read(input string tag, input logic [2:0] a,
                           input logic [31:0] exp_a, input logic [31:0] exp_b);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        chk({tag, "_vb1"}, 32'(rd_valid_b), 32'd1);
        chk({tag, "_db"},  rd_data_b, exp_b);
        chk({tag, "_va1"}, 32'(rd_valid_a), 32'd0);
        tick();
        chk({tag, "_va2"}, 32'(rd_valid_a), 32'd1);
        chk({tag, "_da"},  rd_data_a, exp_a);
        chk({tag, "_vb2"}, 32'(rd_valid_b), 32'd0);
    endtask

    task automatic busy_len(input string tag, input int exp);
        int cnt = 0;
        while (busy_a && cnt < 50) begin
            cnt++;
            tick();
        end
        chk(tag, 32'(cnt), 32'(exp));
        chk({tag, "_b"}, 32'(busy_b), 32'd0);
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            do_read($sformatf("%s%0d", tag, i), 3'(i), 32'h0, 32'h0);
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
        repeat (3) tick();
        chk("rst_busy_a", 32'(busy_a), 32'd1);
        chk("rst_busy_b", 32'(busy_b), 32'd1);
        chk("rst_vld_a",  32'(rd_valid_a), 32'd0);
        chk("rst_data_a", rd_data_a, 32'h0);
        chk("rst_data_b", rd_data_b, 32'h0);

        reset = 1'b0;
        busy_len("init_busy", 9);
        read_all_zero("init_rd");

        do_write(3'd2, 32'h11223344, 4'b1111);
        do_write(3'd2, 32'hAABBCCDD, 4'b0101);
        do_read("be_merge", 3'd2, 32'h11BB33DD, 32'h11BB33DD);

        // Back-to-back reads: addr 0 then addr 2, then check hold.
        rd_en = 1'b1; rd_addr = 3'd0;
        tick();
        rd_addr = 3'd2;
        chk("b2b_vb0", 32'(rd_valid_b), 32'd1);
        chk("b2b_db0", rd_data_b, 32'h0);
        tick();
        rd_en = 1'b0;
        chk("b2b_vb1", 32'(rd_valid_b), 32'd1);
        chk("b2b_db1", rd_data_b, 32'h11BB33DD);
        chk("b2b_va0", 32'(rd_valid_a), 32'd1);
        chk("b2b_da0", rd_data_a, 32'h0);
        tick();
        chk("b2b_va1", 32'(rd_valid_a), 32'd1);
        chk("b2b_da1", rd_data_a, 32'h11BB33DD);
        chk("b2b_vb_off", 32'(rd_valid_b), 32'd0);
        chk("b2b_db_hold", rd_data_b, 32'h11BB33DD);
        tick();
        chk("b2b_va_off", 32'(rd_valid_a), 32'd0);
        chk("b2b_da_hold", rd_data_a, 32'h11BB33DD);

        // Same-address read during write.
        do_write(3'd5, 32'h01020304, 4'b1111);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'hFFFFFFFF; wr_be = 4'b0011;
        do_read("rdw", 3'd5, 32'h01020304, 32'h0102FFFF);
        do_read("rdw_after", 3'd5, 32'h0102FFFF, 32'h0102FFFF);

        // Clear request with a read accepted in the same cycle, then traffic during the sweep.
        clear = 1'b1; rd_en = 1'b1; rd_addr = 3'd2;
        tick();
        clear = 1'b0; rd_en = 1'b0;
        chk("clr_busy", 32'(busy_a), 32'd1);
        chk("clr_pre_vb", 32'(rd_valid_b), 32'd1);
        chk("clr_pre_db", rd_data_b, 32'h11BB33DD);
        chk("clr_pre_va0", 32'(rd_valid_a), 32'd0);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h12345678; wr_be = 4'b1111;
        rd_en = 1'b1; rd_addr = 3'd5;
        tick();
        chk("clr_pre_va", 32'(rd_valid_a), 32'd1);
        chk("clr_pre_da", rd_data_a, 32'h11BB33DD);
        chk("clr_busy_vb", 32'(rd_valid_b), 32'd0);
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("clr_busy_va", 32'(rd_valid_a), 32'd0);
        chk("clr_busy_vb2", 32'(rd_valid_b), 32'd0);
        chk("clr_hold_db", rd_data_b, 32'h11BB33DD);
        busy_len("clr_busy_rem", 6);
        read_all_zero("clr_rd");

        // Reset in the middle of a sweep.
        do_write(3'd7, 32'hDEADBEEF, 4'b1111);
        do_read("pre_abort", 3'd7, 32'hDEADBEEF, 32'hDEADBEEF);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("abort_busy_a", 32'(busy_a), 32'd1);
        chk("abort_vld_a", 32'(rd_valid_a), 32'd0);
        chk("abort_data_a", rd_data_a, 32'h0);
        chk("abort_data_b", rd_data_b, 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        busy_len("abort_busy", 9);
        read_all_zero("abort_rd");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
